// File: rtl/axis_switch_route_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_switch_route_ctrl_if                                                |
// | Route-request handshake, slave-port taps and switch enables/status.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface axis_switch_route_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_en;
  logic       s0_axis_tvalid;
  logic       s0_axis_tready;
  logic       s0_axis_tlast;
  logic       s1_axis_tvalid;
  logic       s1_axis_tready;
  logic       s1_axis_tlast;
  logic       m0_en;
  logic       m1_en;
  logic       s0_en;
  logic       s1_en;
  logic       pending;
  logic       applied;
  logic       timeout;

  // master: requester / traffic side, slave: the route controller
  modport master (
    output cfg_valid, cfg_en,
    output s0_axis_tvalid, s0_axis_tready, s0_axis_tlast,
    output s1_axis_tvalid, s1_axis_tready, s1_axis_tlast,
    input  cfg_ready, m0_en, m1_en, s0_en, s1_en, pending, applied, timeout
  );

  modport slave (
    input  cfg_valid, cfg_en,
    input  s0_axis_tvalid, s0_axis_tready, s0_axis_tlast,
    input  s1_axis_tvalid, s1_axis_tready, s1_axis_tlast,
    output cfg_ready, m0_en, m1_en, s0_en, s1_en, pending, applied, timeout
  );
endinterface
`default_nettype wire

// File: rtl/axis_switch_route_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_switch_route_ctrl                                                   |
// | Applies 2x2 switch route changes only on packet boundaries, with timeout.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_switch_route_ctrl #(
  parameter logic [3:0]  RST_EN  = 4'b0000,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 16
) (
  input  wire logic               aclk,
  input  wire logic               aresetn,
  axis_switch_route_ctrl_if.slave bus
);

  localparam logic [0:0]      c_idle    = 1'b0;
  localparam logic [0:0]      c_pending = 1'b1;
  localparam logic [TO_W-1:0] c_to_last = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [3:0]      r_en;
  logic [3:0]      r_req;
  logic [3:0]      w_new_en;
  logic [TO_W-1:0] r_cnt;
  logic            r_pkt0;
  logic            r_pkt1;
  logic            r_applied;
  logic            r_timeout;
  logic            w_hs0;
  logic            w_hs1;
  logic            w_pkt0_nxt;
  logic            w_pkt1_nxt;
  logic            w_boundary;
  logic            w_accept;
  logic            w_apply;
  logic            w_force;

  assign w_hs0      = bus.s0_axis_tvalid && bus.s0_axis_tready;
  assign w_hs1      = bus.s1_axis_tvalid && bus.s1_axis_tready;
  assign w_pkt0_nxt = r_pkt0 ? !(w_hs0 && bus.s0_axis_tlast) : (w_hs0 && !bus.s0_axis_tlast);
  assign w_pkt1_nxt = r_pkt1 ? !(w_hs1 && bus.s1_axis_tlast) : (w_hs1 && !bus.s1_axis_tlast);
  // Boundary looks at the post-beat packet state so a closing tlast counts now.
  assign w_boundary = !w_pkt0_nxt && !w_pkt1_nxt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    w_force     = 1'b0;
    w_new_en    = r_req;
    case (r_state)
      c_idle: begin
        w_new_en = bus.cfg_en;
        if (bus.cfg_valid) begin
          w_accept = 1'b1;
          if (w_boundary) begin
            w_apply = 1'b1;
          end else begin
            w_state_nxt = c_pending;
          end
        end
      end
      c_pending: begin
        if (w_boundary) begin
          w_apply     = 1'b1;
          w_state_nxt = c_idle;
        end else if ((TIMEOUT != 0) && (r_cnt == c_to_last)) begin
          w_apply     = 1'b1;
          w_force     = 1'b1;
          w_state_nxt = c_idle;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    bus.cfg_ready = (r_state == c_idle);
    bus.pending   = (r_state == c_pending);
    bus.m1_en     = r_en[3];
    bus.m0_en     = r_en[2];
    bus.s1_en     = r_en[1];
    bus.s0_en     = r_en[0];
    bus.applied   = r_applied;
    bus.timeout   = r_timeout;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en      <= RST_EN;
      r_req     <= '0;
      r_cnt     <= '0;
      r_pkt0    <= 1'b0;
      r_pkt1    <= 1'b0;
      r_applied <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pkt0    <= w_pkt0_nxt;
      r_pkt1    <= w_pkt1_nxt;
      r_applied <= w_apply;
      r_timeout <= w_force;
      if (w_accept) begin
        r_req <= bus.cfg_en;
      end
      if (w_apply) begin
        r_en <= w_new_en;
      end
      if (r_state == c_pending) begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + TO_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_switch_route_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_switch_route_ctrl                                                |
// | Directed and random bench against a cycle-level reference of the router. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axis_switch_route_ctrl;

  localparam logic [3:0] c_rst_en  = 4'b0101;
  localparam int         c_timeout = 8;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  axis_switch_route_ctrl_if bus ();

  axis_switch_route_ctrl #(
    .RST_EN  (c_rst_en),
    .TIMEOUT (c_timeout),
    .TO_W    (16)
  ) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a packet is open after a cycle if it was open and did not end,
  // or a non-final beat was accepted; a waiting request counts elapsed cycles.
  function automatic logic open_after(input logic open, input logic v, input logic r, input logic l);
    return open ? !(v && r && l) : (v && r && !l);
  endfunction

  logic       m_pkt0, m_pkt1, m_busy, m_applied, m_timeout;
  logic [3:0] m_en, m_req;
  int         m_wait;
  logic       m_open0, m_open1, m_bnd;

  assign m_open0 = open_after(m_pkt0, bus.s0_axis_tvalid, bus.s0_axis_tready, bus.s0_axis_tlast);
  assign m_open1 = open_after(m_pkt1, bus.s1_axis_tvalid, bus.s1_axis_tready, bus.s1_axis_tlast);
  assign m_bnd   = !m_open0 && !m_open1;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_en <= c_rst_en; m_req <= 4'b0000; m_busy <= 1'b0; m_wait <= 0;
      m_applied <= 1'b0; m_timeout <= 1'b0; m_pkt0 <= 1'b0; m_pkt1 <= 1'b0;
    end else begin
      m_pkt0    <= m_open0;
      m_pkt1    <= m_open1;
      m_applied <= 1'b0;
      m_timeout <= 1'b0;
      if (!m_busy) begin
        if (bus.cfg_valid) begin
          if (m_bnd) begin
            m_en <= bus.cfg_en; m_applied <= 1'b1;
          end else begin
            m_busy <= 1'b1; m_req <= bus.cfg_en; m_wait <= 0;
          end
        end
      end else begin
        m_wait <= m_wait + 1;
        if (m_bnd) begin
          m_en <= m_req; m_applied <= 1'b1; m_busy <= 1'b0;
        end else if (m_wait + 1 == c_timeout) begin
          m_en <= m_req; m_applied <= 1'b1; m_timeout <= 1'b1; m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (cyc > 0) begin
      chk("m_en",      {bus.m1_en, bus.m0_en, bus.s1_en, bus.s0_en}, m_en);
      chk("m_ready",   {3'b000, bus.cfg_ready}, {3'b000, !m_busy});
      chk("m_pending", {3'b000, bus.pending},   {3'b000, m_busy});
      chk("m_applied", {3'b000, bus.applied},   {3'b000, m_applied});
      chk("m_timeout", {3'b000, bus.timeout},   {3'b000, m_timeout});
    end
  end

  task automatic set_s0(input logic v, input logic r, input logic l);
    bus.s0_axis_tvalid = v; bus.s0_axis_tready = r; bus.s0_axis_tlast = l;
  endtask

  task automatic set_s1(input logic v, input logic r, input logic l);
    bus.s1_axis_tvalid = v; bus.s1_axis_tready = r; bus.s1_axis_tlast = l;
  endtask

  function automatic logic [3:0] dut_en();
    return {bus.m1_en, bus.m0_en, bus.s1_en, bus.s0_en};
  endfunction

  initial begin
    int   t_pend;
    int   t_app;
    logic found;
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 4'b0000;
    set_s0(1'b0, 1'b0, 1'b0);
    set_s1(1'b0, 1'b0, 1'b0);
    #1 aresetn = 1'b0;

    // Reset values
    repeat (3) @(negedge aclk);
    chk("rst_en",      dut_en(), 4'b0101);
    chk("rst_ready",   {3'b000, bus.cfg_ready}, 4'b0001);
    chk("rst_pending", {3'b000, bus.pending},   4'b0000);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_en", dut_en(), 4'b0101);

    // Idle request applies in one cycle
    bus.cfg_valid = 1'b1; bus.cfg_en = 4'b1010;
    @(negedge aclk);
    bus.cfg_valid = 1'b0;
    chk("t2_en",      dut_en(), 4'b1010);
    chk("t2_applied", {3'b000, bus.applied}, 4'b0001);
    chk("t2_pending", {3'b000, bus.pending}, 4'b0000);
    @(negedge aclk);
    chk("t2_pulse_end", {3'b000, bus.applied}, 4'b0000);

    // s0 mid-packet: request waits for the closing beat
    repeat (3) begin
      set_s0(1'b1, 1'b1, 1'b0);
      @(negedge aclk);
    end
    set_s0(1'b0, 1'b1, 1'b0);
    bus.cfg_valid = 1'b1; bus.cfg_en = 4'b0110;
    @(negedge aclk);
    bus.cfg_valid = 1'b0;
    chk("t3_pending", {3'b000, bus.pending}, 4'b0001);
    chk("t3_hold_en", dut_en(), 4'b1010);
    repeat (2) @(negedge aclk);
    set_s0(1'b1, 1'b1, 1'b1);
    @(negedge aclk);
    set_s0(1'b0, 1'b0, 1'b0);
    chk("t3_en",      dut_en(), 4'b0110);
    chk("t3_applied", {3'b000, bus.applied},   4'b0001);
    chk("t3_ready",   {3'b000, bus.cfg_ready}, 4'b0001);

    // s1 stalled mid-packet: forced apply after TIMEOUT cycles
    @(negedge aclk);
    set_s1(1'b1, 1'b1, 1'b0);
    @(negedge aclk);
    set_s1(1'b1, 1'b0, 1'b0);
    bus.cfg_valid = 1'b1; bus.cfg_en = 4'b1001;
    @(negedge aclk);
    t_pend = cyc;
    chk("t4_pending", {3'b000, bus.pending},   4'b0001);
    chk("t4_ready",   {3'b000, bus.cfg_ready}, 4'b0000);
    bus.cfg_en = 4'b1111;
    @(negedge aclk);
    bus.cfg_valid = 1'b0;
    found = 1'b0;
    t_app = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (bus.applied === 1'b1) begin
        found = 1'b1;
        t_app = cyc;
        chk("t4_timeout", {3'b000, bus.timeout}, 4'b0001);
        chk("t4_en",      dut_en(), 4'b1001);
      end else begin
        @(negedge aclk);
      end
    end
    chk("t4_seen",    {3'b000, found}, 4'b0001);
    chk("t4_latency", 4'(t_app - t_pend), 4'd8);
    set_s1(1'b1, 1'b1, 1'b1);
    @(negedge aclk);
    set_s1(1'b0, 1'b0, 1'b0);

    // Same-cycle single-beat packet vs same-cycle packet start
    @(negedge aclk);
    set_s0(1'b1, 1'b1, 1'b1);
    bus.cfg_valid = 1'b1; bus.cfg_en = 4'b0011;
    @(negedge aclk);
    set_s0(1'b0, 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    chk("t5_applied", {3'b000, bus.applied}, 4'b0001);
    chk("t5_en",      dut_en(), 4'b0011);
    set_s1(1'b1, 1'b1, 1'b0);
    bus.cfg_valid = 1'b1; bus.cfg_en = 4'b1100;
    @(negedge aclk);
    set_s1(1'b0, 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    chk("t5_pending", {3'b000, bus.pending}, 4'b0001);
    chk("t5_hold_en", dut_en(), 4'b0011);

    // Asynchronous reset while pending
    #2 aresetn = 1'b0;
    #1;
    chk("t6_en",      dut_en(), 4'b0101);
    chk("t6_pending", {3'b000, bus.pending}, 4'b0000);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("t6_no_apply", {3'b000, bus.applied}, 4'b0000);
    end

    // Random traffic and requests
    for (int i = 0; i < 4000; i++) begin
      set_s0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      set_s1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
      bus.cfg_valid = ($urandom_range(0, 3) == 0);
      bus.cfg_en    = 4'($urandom);
      if (i == 2000) begin
        #2 aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
      end else begin
        @(negedge aclk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
